multicycle_control: RTL and testbench

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/multicycle_control_pkg.sv | 133 +++++++++++++
 rtl/multicycle_control_aludecoder.sv | 32 +++
 rtl/multicycle_control.sv | 122 ++++++++++++
 tb/tb_multicycle_control.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_control_pkg.sv
// Shared types for the multicycle MIPS-style controller: state encodings, opcodes, ALUOp/ALUControl codes, control word.
// Latency: n/a (types, constants and one pure decode function only).
// Backpressure: n/a.
package multicycle_control_pkg;

   // FSM state encodings; the numeric values are visible on the State debug port
   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECUTE  = 4'd6,
      S_ALUWB    = 4'd7,
      S_BRANCH   = 4'd8,
      S_ADDIEX   = 4'd9,
      S_ADDIWB   = 4'd10,
      S_JUMP     = 4'd11,
      S_TRAP     = 4'd12
   } state_t;

   // Instruction opcodes recognised in DECODE
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   // ALUOp codes passed from the FSM to the ALU decoder
   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;
   localparam logic [1:0] ALUOP_RSVD  = 2'b11;

   // R-type function fields with a dedicated ALU operation
   localparam logic [5:0] FN_ADD   = 6'b100000;
   localparam logic [5:0] FN_SUB   = 6'b100010;
   localparam logic [5:0] FN_SLT   = 6'b101010;
   localparam logic [5:0] FN_SPEC2 = 6'b011100;

   // ALUControl encodings
   localparam logic [2:0] ALUCTL_ADD   = 3'b010;
   localparam logic [2:0] ALUCTL_SUB   = 3'b100;
   localparam logic [2:0] ALUCTL_SLT   = 3'b110;
   localparam logic [2:0] ALUCTL_SPEC2 = 3'b101;

   // Registered per-state control word. The *_on_rdy bits are later ANDed
   // with MemReady; mem_wait marks the states that wait on memory.
   typedef struct packed {
      logic       iord;
      logic       irwrite_on_rdy;
      logic       memwrite;
      logic       regdst;
      logic       memtoreg;
      logic       regwrite;
      logic       alusrca;
      logic [1:0] alusrcb;
      logic [1:0] pcsrc;
      logic       pcwrite;
      logic       pcwrite_on_rdy;
      logic       branch;
      logic [1:0] aluop;
      logic       mem_wait;
   } ctrl_t;

   // Moore decode of one state into its control word; anything not set is 0
   function automatic ctrl_t state_ctrl(input state_t s);
      ctrl_t c;
      c = '0;
      case (s)
         S_FETCH: begin
            c.alusrcb        = 2'b01;
            c.aluop          = ALUOP_ADD;
            c.irwrite_on_rdy = 1'b1;
            c.pcwrite_on_rdy = 1'b1;
            c.mem_wait       = 1'b1;
         end
         S_DECODE: begin
            c.alusrcb = 2'b11;
            c.aluop   = ALUOP_ADD;
         end
         S_MEMADR: begin
            c.alusrca = 1'b1;
            c.alusrcb = 2'b10;
            c.aluop   = ALUOP_ADD;
         end
         S_MEMREAD: begin
            c.iord     = 1'b1;
            c.mem_wait = 1'b1;
         end
         S_MEMWB: begin
            c.memtoreg = 1'b1;
            c.regwrite = 1'b1;
         end
         S_MEMWRITE: begin
            c.iord     = 1'b1;
            c.memwrite = 1'b1;
            c.mem_wait = 1'b1;
         end
         S_EXECUTE: begin
            c.alusrca = 1'b1;
            c.aluop   = ALUOP_FUNCT;
         end
         S_ALUWB: begin
            c.regdst   = 1'b1;
            c.regwrite = 1'b1;
         end
         S_BRANCH: begin
            c.alusrca = 1'b1;
            c.aluop   = ALUOP_SUB;
            c.pcsrc   = 2'b01;
            c.branch  = 1'b1;
         end
         S_ADDIEX: begin
            c.alusrca = 1'b1;
            c.alusrcb = 2'b10;
            c.aluop   = ALUOP_ADD;
         end
         S_ADDIWB: begin
            c.regwrite = 1'b1;
         end
         S_JUMP: begin
            c.pcsrc   = 2'b10;
            c.pcwrite = 1'b1;
         end
         default: c = '0;   // TRAP and unused encodings drive nothing
      endcase
      return c;
   endfunction

endpackage

// File: rtl/multicycle_control_aludecoder.sv
// ALU decoder: maps ALUOp and the R-type function field to the ALU operation code.
// Latency: purely combinational, zero cycles.
// Backpressure: none.
module ALUDecoder
   import multicycle_control_pkg::*;
(
   input  logic [1:0] i_aluop,
   input  logic [5:0] i_funct,
   output logic [2:0] o_alucontrol
);

   // Select the ALU operation; unknown function fields and the reserved ALUOp fall back to add
   always_comb begin
      o_alucontrol = ALUCTL_ADD;
      case (i_aluop)
         ALUOP_ADD: o_alucontrol = ALUCTL_ADD;
         ALUOP_SUB: o_alucontrol = ALUCTL_SUB;
         ALUOP_FUNCT: begin
            case (i_funct)
               FN_ADD:   o_alucontrol = ALUCTL_ADD;
               FN_SUB:   o_alucontrol = ALUCTL_SUB;
               FN_SLT:   o_alucontrol = ALUCTL_SLT;
               FN_SPEC2: o_alucontrol = ALUCTL_SPEC2;
               default:  o_alucontrol = ALUCTL_ADD;
            endcase
         end
         ALUOP_RSVD: o_alucontrol = ALUCTL_ADD;
         default:    o_alucontrol = ALUCTL_ADD;
      endcase
   end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle CPU control FSM with memory-wait counter/timeout; optional illegal-opcode trap via ILLEGAL_OP_TRAP_EN.
// Latency: one state per clock; outputs are registered with the state, except MemReady-gated writes, PCEn and ALUControl.
// Backpressure: FETCH, MEMREAD and MEMWRITE hold until MemReady; MemTimeout only flags a long wait, it never forces a transition.
module multicycle_control
   import multicycle_control_pkg::*;
#(
   parameter int MEM_WAIT_MAX = 15
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] Op,
   input  logic [5:0] Funct,
   input  logic       Zero,
   input  logic       MemReady,
   output logic       IorD,
   output logic       IRWrite,
   output logic       MemWrite,
   output logic       RegDst,
   output logic       MemtoReg,
   output logic       RegWrite,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] PCSrc,
   output logic       PCEn,
   output logic [2:0] ALUControl,
   output logic       MemTimeout,
   output logic [3:0] State
);

   localparam logic [7:0] WAIT_MAX = 8'(MEM_WAIT_MAX);

   state_t     r_state;
   ctrl_t      r_ctrl;
   logic [7:0] r_wait_cnt;

   state_t     w_next;
   logic [7:0] w_wait_cnt_nxt;
   logic       w_waiting;
   logic       w_pcwrite;

   // Next-state selection; MemReady is only consulted in the memory-wait states
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_FETCH:    if (MemReady) w_next = S_DECODE;
         S_DECODE: begin
            case (Op)
               OP_LW, OP_SW: w_next = S_MEMADR;
               OP_RTYPE:     w_next = S_EXECUTE;
               OP_BEQ:       w_next = S_BRANCH;
               OP_ADDI:      w_next = S_ADDIEX;
               OP_J:         w_next = S_JUMP;
`ifdef ILLEGAL_OP_TRAP_EN
               default:      w_next = S_TRAP;
`else
               default:      w_next = S_FETCH;   // unknown opcode retires as a NOP
`endif
            endcase
         end
         S_MEMADR: begin
            if (Op == OP_LW)      w_next = S_MEMREAD;
            else if (Op == OP_SW) w_next = S_MEMWRITE;
            else                  w_next = S_FETCH;   // opcode changed under us: abandon
         end
         S_MEMREAD:  if (MemReady) w_next = S_MEMWB;
         S_MEMWRITE: if (MemReady) w_next = S_FETCH;
         S_EXECUTE:  w_next = S_ALUWB;
         S_ADDIEX:   w_next = S_ADDIWB;
`ifdef ILLEGAL_OP_TRAP_EN
         S_TRAP:     w_next = S_TRAP;    // only reset leaves the trap
`else
         S_TRAP:     w_next = S_FETCH;
`endif
         default:    w_next = S_FETCH;   // write-back, branch, jump and unused encodings
      endcase
   end

   // Wait counter: counts stalled cycles in a memory state, saturates, and is
   // zero on every entry because any cycle that is not a stall reloads it with 0
   always_comb begin
      w_waiting      = r_ctrl.mem_wait & ~MemReady;
      w_wait_cnt_nxt = 8'd0;
      if (w_waiting) begin
         w_wait_cnt_nxt = (r_wait_cnt >= WAIT_MAX) ? WAIT_MAX : (r_wait_cnt + 8'd1);
      end
   end

   // State, registered control word and wait counter; reset lands in FETCH with FETCH controls
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= S_FETCH;
         r_ctrl     <= state_ctrl(S_FETCH);
         r_wait_cnt <= 8'd0;
      end else begin
         r_state    <= w_next;
         r_ctrl     <= state_ctrl(w_next);
         r_wait_cnt <= w_wait_cnt_nxt;
      end
   end

   ALUDecoder u_aludec (
      .i_aluop      (r_ctrl.aluop),
      .i_funct      (Funct),
      .o_alucontrol (ALUControl)
   );

   assign w_pcwrite  = r_ctrl.pcwrite | (r_ctrl.pcwrite_on_rdy & MemReady);

   assign IorD       = r_ctrl.iord;
   assign IRWrite    = r_ctrl.irwrite_on_rdy & MemReady;
   assign MemWrite   = r_ctrl.memwrite;
   assign RegDst     = r_ctrl.regdst;
   assign MemtoReg   = r_ctrl.memtoreg;
   assign RegWrite   = r_ctrl.regwrite;
   assign ALUSrcA    = r_ctrl.alusrca;
   assign ALUSrcB    = r_ctrl.alusrcb;
   assign PCSrc      = r_ctrl.pcsrc;
   assign PCEn       = w_pcwrite | (r_ctrl.branch & Zero);
   assign MemTimeout = w_waiting & (r_wait_cnt == WAIT_MAX);
   assign State      = r_state;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: vector table plus hand-written wait, reset and illegal-opcode sequences.
// Latency: checks land 2 ns after inputs change, one clock per step.
// Backpressure: stimulus drives MemReady directly.
module tb_multicycle_control;

   logic       clk, reset;
   logic [5:0] Op, Funct;
   logic       Zero, MemReady;
   logic       IorD, IRWrite, MemWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
   logic [1:0] ALUSrcB, PCSrc;
   logic       PCEn;
   logic [2:0] ALUControl;
   logic       MemTimeout;
   logic [3:0] State;

   multicycle_control #(.MEM_WAIT_MAX(15)) dut (
      .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Zero(Zero), .MemReady(MemReady),
      .IorD(IorD), .IRWrite(IRWrite), .MemWrite(MemWrite), .RegDst(RegDst),
      .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
      .PCSrc(PCSrc), .PCEn(PCEn), .ALUControl(ALUControl), .MemTimeout(MemTimeout),
      .State(State)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [5:0]  op;
      logic [5:0]  funct;
      logic        zero;
      logic        mr;
      logic [3:0]  st;
      logic [15:0] out;
   } vec_t;

   typedef struct {
      string       nm;
      logic [3:0]  st;
      logic [15:0] out;
   } exp_t;

   vec_t vecs[$];
   exp_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
   localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, JMP = 6'b000010, ILL = 6'b111111;

   logic [15:0] E_FETCH_RDY, E_FETCH_WAIT, E_DECODE, E_MEMADR, E_MEMREAD, E_MEMWB;
   logic [15:0] E_MEMWRITE, E_ALUWB, E_ADDIWB, E_JUMP, E_TRAP;

   // {IorD,IRWrite,MemWrite,RegDst,MemtoReg,RegWrite,ALUSrcA,ALUSrcB,PCSrc,PCEn,ALUControl,MemTimeout}
   function automatic logic [15:0] ov(input logic iord, irw, mw, rd, m2r, rw, asa,
                                      input logic [1:0] asb, pcs, input logic pcen,
                                      input logic [2:0] aluc, input logic mto);
      return {iord, irw, mw, rd, m2r, rw, asa, asb, pcs, pcen, aluc, mto};
   endfunction

   function automatic logic [15:0] e_exec(input logic [2:0] aluc);
      return ov(0,0,0,0,0,0,1,2'b00,2'b00,0,aluc,0);
   endfunction

   function automatic logic [15:0] e_branch(input logic pcen);
      return ov(0,0,0,0,0,0,1,2'b00,2'b01,pcen,3'b100,0);
   endfunction

   function automatic logic [15:0] e_memwrite_to(input logic mto);
      return ov(1,0,1,0,0,0,0,2'b00,2'b00,0,3'b010,mto);
   endfunction

   function automatic logic [15:0] e_fetch_wait_to(input logic mto);
      return ov(0,0,0,0,0,0,0,2'b01,2'b00,0,3'b010,mto);
   endfunction

   task automatic addv(input logic [5:0] op, funct, input logic zero, mr,
                       input logic [3:0] st, input logic [15:0] out);
      vec_t v;
      v.op = op; v.funct = funct; v.zero = zero; v.mr = mr; v.st = st; v.out = out;
      vecs.push_back(v);
   endtask

   task automatic expect_now(input string nm, input logic [3:0] st, input logic [15:0] out);
      exp_t e;
      e.nm = nm; e.st = st; e.out = out;
      sb.push_back(e);
   endtask

   task automatic compare_out();
      exp_t        e;
      logic [15:0] act;
      e   = sb.pop_front();
      act = {IorD, IRWrite, MemWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
             ALUSrcB, PCSrc, PCEn, ALUControl, MemTimeout};
      n_cmp++;
      if (State !== e.st) begin
         n_bad++;
         $display("FAIL %s state: got %0d want %0d", e.nm, State, e.st);
      end
      n_cmp++;
      if (act !== e.out) begin
         n_bad++;
         $display("FAIL %s outputs: got %b want %b", e.nm, act, e.out);
      end
   endtask

   // Drive one cycle's inputs, check the current-state outputs, then advance one clock
   task automatic step(input string nm, input logic [5:0] op, funct, input logic zero, mr,
                       input logic [3:0] st, input logic [15:0] out);
      Op = op; Funct = funct; Zero = zero; MemReady = mr;
      expect_now(nm, st, out);
      #2;
      compare_out();
      @(posedge clk);
      #1;
   endtask

   initial begin
      E_FETCH_RDY  = ov(0,1,0,0,0,0,0,2'b01,2'b00,1,3'b010,0);
      E_FETCH_WAIT = e_fetch_wait_to(1'b0);
      E_DECODE     = ov(0,0,0,0,0,0,0,2'b11,2'b00,0,3'b010,0);
      E_MEMADR     = ov(0,0,0,0,0,0,1,2'b10,2'b00,0,3'b010,0);
      E_MEMREAD    = ov(1,0,0,0,0,0,0,2'b00,2'b00,0,3'b010,0);
      E_MEMWB      = ov(0,0,0,0,1,1,0,2'b00,2'b00,0,3'b010,0);
      E_MEMWRITE   = e_memwrite_to(1'b0);
      E_ALUWB      = ov(0,0,0,1,0,1,0,2'b00,2'b00,0,3'b010,0);
      E_ADDIWB     = ov(0,0,0,0,0,1,0,2'b00,2'b00,0,3'b010,0);
      E_JUMP       = ov(0,0,0,0,0,0,0,2'b00,2'b10,1,3'b010,0);
      E_TRAP       = ov(0,0,0,0,0,0,0,2'b00,2'b00,0,3'b010,0);

      // lw, all memory ready
      addv(LW, 6'd0, 0, 1, 4'd0, E_FETCH_RDY);
      addv(LW, 6'd0, 0, 1, 4'd1, E_DECODE);
      addv(LW, 6'd0, 0, 1, 4'd2, E_MEMADR);
      addv(LW, 6'd0, 0, 1, 4'd3, E_MEMREAD);
      addv(LW, 6'd0, 0, 1, 4'd4, E_MEMWB);
      // R-type slt, sub, special2, unknown funct
      addv(RT, 6'b101010, 0, 1, 4'd0, E_FETCH_RDY);
      addv(RT, 6'b101010, 0, 1, 4'd1, E_DECODE);
      addv(RT, 6'b101010, 0, 1, 4'd6, e_exec(3'b110));
      addv(RT, 6'b101010, 0, 1, 4'd7, E_ALUWB);
      addv(RT, 6'b100010, 0, 1, 4'd0, E_FETCH_RDY);
      addv(RT, 6'b100010, 0, 1, 4'd1, E_DECODE);
      addv(RT, 6'b100010, 0, 1, 4'd6, e_exec(3'b100));
      addv(RT, 6'b100010, 0, 1, 4'd7, E_ALUWB);
      addv(RT, 6'b011100, 0, 1, 4'd0, E_FETCH_RDY);
      addv(RT, 6'b011100, 0, 1, 4'd1, E_DECODE);
      addv(RT, 6'b011100, 0, 1, 4'd6, e_exec(3'b101));
      addv(RT, 6'b011100, 0, 1, 4'd7, E_ALUWB);
      addv(RT, 6'b111111, 0, 1, 4'd0, E_FETCH_RDY);
      addv(RT, 6'b111111, 0, 1, 4'd1, E_DECODE);
      addv(RT, 6'b111111, 0, 1, 4'd6, e_exec(3'b010));
      addv(RT, 6'b111111, 0, 1, 4'd7, E_ALUWB);
      // beq taken / not taken
      addv(BEQ, 6'd0, 1, 1, 4'd0, E_FETCH_RDY);
      addv(BEQ, 6'd0, 1, 1, 4'd1, E_DECODE);
      addv(BEQ, 6'd0, 1, 1, 4'd8, e_branch(1'b1));
      addv(BEQ, 6'd0, 0, 1, 4'd0, E_FETCH_RDY);
      addv(BEQ, 6'd0, 0, 1, 4'd1, E_DECODE);
      addv(BEQ, 6'd0, 0, 1, 4'd8, e_branch(1'b0));
      // addi with MemReady low outside memory states (must be ignored)
      addv(ADDI, 6'd0, 0, 1, 4'd0, E_FETCH_RDY);
      addv(ADDI, 6'd0, 0, 0, 4'd1, E_DECODE);
      addv(ADDI, 6'd0, 0, 0, 4'd9, E_MEMADR);
      addv(ADDI, 6'd0, 0, 0, 4'd10, E_ADDIWB);
      // jump
      addv(JMP, 6'd0, 0, 1, 4'd0, E_FETCH_RDY);
      addv(JMP, 6'd0, 0, 0, 4'd1, E_DECODE);
      addv(JMP, 6'd0, 1, 0, 4'd11, E_JUMP);
      // lw with stalls in FETCH and MEMREAD
      addv(LW, 6'd0, 0, 0, 4'd0, E_FETCH_WAIT);
      addv(LW, 6'd0, 0, 0, 4'd0, E_FETCH_WAIT);
      addv(LW, 6'd0, 0, 1, 4'd0, E_FETCH_RDY);
      addv(LW, 6'd0, 0, 1, 4'd1, E_DECODE);
      addv(LW, 6'd0, 0, 1, 4'd2, E_MEMADR);
      addv(LW, 6'd0, 0, 0, 4'd3, E_MEMREAD);
      addv(LW, 6'd0, 0, 0, 4'd3, E_MEMREAD);
      addv(LW, 6'd0, 0, 1, 4'd3, E_MEMREAD);
      addv(LW, 6'd0, 0, 1, 4'd4, E_MEMWB);

      // Reset state, checked with reset still asserted
      reset = 1'b1; Op = 6'd0; Funct = 6'd0; Zero = 1'b0; MemReady = 1'b0;
      @(posedge clk);
      #1;
      expect_now("reset", 4'd0, E_FETCH_WAIT);
      #1;
      compare_out();
      reset = 1'b0;

      for (int i = 0; i < vecs.size(); i++) begin
         step($sformatf("vec[%0d]", i), vecs[i].op, vecs[i].funct, vecs[i].zero,
              vecs[i].mr, vecs[i].st, vecs[i].out);
      end

      // sw with a 20-cycle memory stall: timeout from the 16th wait cycle, MemWrite held
      step("sw fetch", SW, 6'd0, 0, 1, 4'd0, E_FETCH_RDY);
      step("sw decode", SW, 6'd0, 0, 1, 4'd1, E_DECODE);
      step("sw memadr", SW, 6'd0, 0, 1, 4'd2, E_MEMADR);
      for (int k = 1; k <= 20; k++) begin
         step($sformatf("sw wait %0d", k), SW, 6'd0, 0, 0, 4'd5, e_memwrite_to(k >= 16));
      end
      step("sw ready", SW, 6'd0, 0, 1, 4'd5, E_MEMWRITE);
      // Counter cleared on FETCH entry, then saturates again in FETCH
      for (int k = 1; k <= 17; k++) begin
         step($sformatf("fetch wait %0d", k), LW, 6'd0, 0, 0, 4'd0, e_fetch_wait_to(k >= 16));
      end
      step("lw fetch2", LW, 6'd0, 0, 1, 4'd0, E_FETCH_RDY);
      step("lw decode2", LW, 6'd0, 0, 1, 4'd1, E_DECODE);
      step("lw memadr2", LW, 6'd0, 0, 1, 4'd2, E_MEMADR);
      step("lw memread w1", LW, 6'd0, 0, 0, 4'd3, E_MEMREAD);
      step("lw memread w2", LW, 6'd0, 0, 0, 4'd3, E_MEMREAD);

      // Asynchronous reset mid-MEMREAD, no clock edge in between
      #3;
      reset = 1'b1;
      expect_now("async reset", 4'd0, E_FETCH_WAIT);
      #1;
      compare_out();
      @(posedge clk);
      #1;
      expect_now("reset held", 4'd0, E_FETCH_WAIT);
      #1;
      compare_out();
      reset = 1'b0;

      // Illegal opcode
      step("ill fetch", ILL, 6'd0, 0, 1, 4'd0, E_FETCH_RDY);
      step("ill decode", ILL, 6'd0, 0, 0, 4'd1, E_DECODE);
`ifdef ILLEGAL_OP_TRAP_EN
      for (int k = 0; k < 10; k++) begin
         step($sformatf("trap %0d", k), ILL, 6'd0, 1, k[0], 4'd12, E_TRAP);
      end
`else
      step("ill nop", ILL, 6'd0, 0, 0, 4'd0, E_FETCH_WAIT);
      step("ill nop2", LW, 6'd0, 0, 1, 4'd0, E_FETCH_RDY);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
